obj_bg_pixel_mixer: RTL

- Consumer end of the per-pixel layer packets: takes the OBJ row-buffer packet and four BG packets for the current dot.
- Resolves layer priority and fetches the top two opaque layers' colours from palette RAM.
- Applies GBA colour special effects (alpha blend, brighten, darken) and emits one BGR555 pixel per dot to the LCD output stage.
- Runs at 4 clocks per dot: 1232 clocks per line = 308 dots × 4.

---
 rtl/obj_bg_pixel_mixer.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/obj_bg_pixel_mixer.sv
// Per-dot layer mixer: picks the top two opaque layers (OBJ, BG0..BG3, backdrop),
// reads both colours from palette RAM and applies the blend/brighten/darken effect.
module obj_bg_pixel_mixer #(
  parameter int unsigned PAL_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic [7:0]  hcount,
  input  logic [19:0] obj_packet,
  input  logic [19:0] bg0_packet,
  input  logic [19:0] bg1_packet,
  input  logic [19:0] bg2_packet,
  input  logic [19:0] bg3_packet,
  input  logic [15:0] dispcnt,
  input  logic [15:0] bldcnt,
  input  logic [15:0] bldalpha,
  input  logic [15:0] bldy,
  output logic [8:0]  pal_addr,
  input  logic [15:0] pal_data,
  output logic [14:0] pixel_color,
  output logic [7:0]  pixel_col,
  output logic        pixel_valid,
  output logic        overrun
);

  localparam int unsigned NUM_SCAN = 5;
  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned CH_W     = 5;
  localparam logic [2:0]  ID_OBJ      = 3'd4;
  localparam logic [2:0]  ID_BACKDROP = 3'd5;
  localparam logic [4:0]  EV_MAX      = 5'd16;
  localparam logic [1:0]  MODE_ALPHA  = 2'd1;
  localparam logic [1:0]  MODE_BRIGHT = 2'd2;
  localparam logic [1:0]  MODE_DARK   = 2'd3;
  // Scan order OBJ, BG0..BG3: a strict-less compare keeps the earlier entry on ties
  localparam logic [2:0]  SCAN_ID [NUM_SCAN] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3};

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_MIX, S_OUT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  id1_q, id1_d, id2_q, id2_d;
  logic [8:0]  addr2_q, addr2_d;
  logic [1:0]  objmode_q, objmode_d;
  logic [7:0]  col_q, col_d;
  logic        blank_q, blank_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic [4:0]  eva_q, eva_d, evb_q, evb_d, evy_q, evy_d;
  logic [14:0] c1_q, c1_d;
  logic [8:0]  pal_addr_q, pal_addr_d;
  logic [14:0] pixel_color_q, pixel_color_d;
  logic [7:0]  pixel_col_q, pixel_col_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        overrun_q, overrun_d;

  function automatic logic [4:0] sat_ev(input logic [4:0] ev);
    return (ev > EV_MAX) ? EV_MAX : ev;
  endfunction

  function automatic logic [4:0] ch_alpha(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] ea, input logic [4:0] eb);
    logic [9:0] sum;
    logic [5:0] q;
    sum = 10'(a) * 10'(ea) + 10'(b) * 10'(eb);
    q   = 6'(sum >> 4);
    return (q > 6'd31) ? 5'd31 : q[4:0];
  endfunction

  function automatic logic [4:0] ch_bright(input logic [4:0] a, input logic [4:0] ev);
    logic [8:0] p;
    p = 9'(5'd31 - a) * 9'(ev);
    return a + 5'(p >> 4);
  endfunction

  function automatic logic [4:0] ch_dark(input logic [4:0] a, input logic [4:0] ev);
    logic [8:0] p;
    p = 9'(a) * 9'(ev);
    return a - 5'(p >> 4);
  endfunction

  // Per-layer priority, palette address and opacity in scan order
  logic [1:0]          scan_prio [NUM_SCAN];
  logic [8:0]          scan_addr [NUM_SCAN];
  logic [NUM_SCAN-1:0] scan_opq;

  always_comb begin
    scan_prio[0] = obj_packet[19:18];
    scan_prio[1] = bg0_packet[19:18];
    scan_prio[2] = bg1_packet[19:18];
    scan_prio[3] = bg2_packet[19:18];
    scan_prio[4] = bg3_packet[19:18];
    scan_addr[0] = obj_packet[8:0];
    scan_addr[1] = bg0_packet[8:0];
    scan_addr[2] = bg1_packet[8:0];
    scan_addr[3] = bg2_packet[8:0];
    scan_addr[4] = bg3_packet[8:0];
    scan_opq[0]  = dispcnt[12] & ~obj_packet[12];
    scan_opq[1]  = dispcnt[8]  & ~bg0_packet[12];
    scan_opq[2]  = dispcnt[9]  & ~bg1_packet[12];
    scan_opq[3]  = dispcnt[10] & ~bg2_packet[12];
    scan_opq[4]  = dispcnt[11] & ~bg3_packet[12];
  end

  logic       have1_c, have2_c;
  logic [2:0] k1_c, k2_c;
  logic [1:0] pri1_c, pri2_c;
  logic [2:0] id1_c, id2_c;
  logic [8:0] addr1_c, addr2_c;

  // First and second opaque layers; backdrop fills whatever is missing
  always_comb begin
    have1_c = 1'b0;
    k1_c    = '0;
    pri1_c  = '0;
    have2_c = 1'b0;
    k2_c    = '0;
    pri2_c  = '0;
    for (int k = 0; k < NUM_SCAN; k++) begin
      if (scan_opq[k] && (!have1_c || (scan_prio[k] < pri1_c))) begin
        have1_c = 1'b1;
        k1_c    = 3'(k);
        pri1_c  = scan_prio[k];
      end
    end
    for (int k = 0; k < NUM_SCAN; k++) begin
      if (scan_opq[k] && !(have1_c && (3'(k) == k1_c)) &&
          (!have2_c || (scan_prio[k] < pri2_c))) begin
        have2_c = 1'b1;
        k2_c    = 3'(k);
        pri2_c  = scan_prio[k];
      end
    end
    id1_c   = have1_c ? SCAN_ID[k1_c]   : ID_BACKDROP;
    addr1_c = have1_c ? scan_addr[k1_c] : 9'h000;
    id2_c   = have2_c ? SCAN_ID[k2_c]   : ID_BACKDROP;
    addr2_c = have2_c ? scan_addr[k2_c] : 9'h000;
  end

  logic        t1_c, t2_c, semi_c;
  logic [14:0] c2_c, effect_c;

  assign c2_c = pal_data[14:0];

  // Colour effect on the registered first colour and the second colour arriving now
  always_comb begin
    t1_c     = tgt1_q[id1_q];
    t2_c     = tgt2_q[id2_q];
    semi_c   = (id1_q == ID_OBJ) && (objmode_q == 2'd1) && t2_c;
    effect_c = c1_q;
    if (blank_q) begin
      effect_c = 15'h7FFF;
    end else if (semi_c || ((mode_q == MODE_ALPHA) && t1_c && t2_c)) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        effect_c[ch*CH_W +: CH_W] = ch_alpha(c1_q[ch*CH_W +: CH_W], c2_c[ch*CH_W +: CH_W],
                                             eva_q, evb_q);
    end else if ((mode_q == MODE_BRIGHT) && t1_c) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        effect_c[ch*CH_W +: CH_W] = ch_bright(c1_q[ch*CH_W +: CH_W], evy_q);
    end else if ((mode_q == MODE_DARK) && t1_c) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        effect_c[ch*CH_W +: CH_W] = ch_dark(c1_q[ch*CH_W +: CH_W], evy_q);
    end
  end

  logic accept_c;
  assign accept_c = pixel_en && ((state_q == S_IDLE) || (state_q == S_OUT));

  // Next-state and datapath loads
  always_comb begin
    state_d       = state_q;
    id1_d         = id1_q;
    id2_d         = id2_q;
    addr2_d       = addr2_q;
    objmode_d     = objmode_q;
    col_d         = col_q;
    blank_d       = blank_q;
    mode_d        = mode_q;
    tgt1_d        = tgt1_q;
    tgt2_d        = tgt2_q;
    eva_d         = eva_q;
    evb_d         = evb_q;
    evy_d         = evy_q;
    c1_d          = c1_q;
    pal_addr_d    = pal_addr_q;
    pixel_color_d = pixel_color_q;
    pixel_col_d   = pixel_col_q;
    pixel_valid_d = 1'b0;
    overrun_d     = overrun_q;
    case (state_q)
      S_IDLE: if (pixel_en) state_d = S_RD1;
      S_RD1: begin
        state_d    = S_RD2;
        pal_addr_d = addr2_q;
        overrun_d  = overrun_q | pixel_en;
      end
      S_RD2: begin
        state_d   = S_MIX;
        c1_d      = pal_data[14:0];
        overrun_d = overrun_q | pixel_en;
      end
      S_MIX: begin
        state_d       = S_OUT;
        pixel_color_d = effect_c;
        pixel_col_d   = col_q;
        pixel_valid_d = 1'b1;
        overrun_d     = overrun_q | pixel_en;
      end
      S_OUT:   state_d = pixel_en ? S_RD1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept_c) begin
      id1_d      = id1_c;
      id2_d      = id2_c;
      addr2_d    = addr2_c;
      pal_addr_d = addr1_c;
      objmode_d  = obj_packet[14:13];
      col_d      = hcount;
      blank_d    = dispcnt[7];
      mode_d     = bldcnt[7:6];
      tgt1_d     = {2'b00, bldcnt[5:0]};
      tgt2_d     = {2'b00, bldcnt[13:8]};
      eva_d      = sat_ev(bldalpha[4:0]);
      evb_d      = sat_ev(bldalpha[12:8]);
      evy_d      = sat_ev(bldy[4:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      id1_q         <= ID_BACKDROP;
      id2_q         <= ID_BACKDROP;
      addr2_q       <= '0;
      objmode_q     <= '0;
      col_q         <= '0;
      blank_q       <= 1'b0;
      mode_q        <= '0;
      tgt1_q        <= '0;
      tgt2_q        <= '0;
      eva_q         <= '0;
      evb_q         <= '0;
      evy_q         <= '0;
      c1_q          <= '0;
      pal_addr_q    <= '0;
      pixel_color_q <= '0;
      pixel_col_q   <= '0;
      pixel_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      id1_q         <= id1_d;
      id2_q         <= id2_d;
      addr2_q       <= addr2_d;
      objmode_q     <= objmode_d;
      col_q         <= col_d;
      blank_q       <= blank_d;
      mode_q        <= mode_d;
      tgt1_q        <= tgt1_d;
      tgt2_q        <= tgt2_d;
      eva_q         <= eva_d;
      evb_q         <= evb_d;
      evy_q         <= evy_d;
      c1_q          <= c1_d;
      pal_addr_q    <= pal_addr_d;
      pixel_color_q <= pixel_color_d;
      pixel_col_q   <= pixel_col_d;
      pixel_valid_q <= pixel_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pal_addr    = pal_addr_q;
  assign pixel_color = pixel_color_q;
  assign pixel_col   = pixel_col_q;
  assign pixel_valid = pixel_valid_q;
  assign overrun     = overrun_q;

  // Producer tags, reserved bits and unused register fields carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{obj_packet[17:15], obj_packet[11:9],
                         bg0_packet[17:13], bg0_packet[11:9],
                         bg1_packet[17:13], bg1_packet[11:9],
                         bg2_packet[17:13], bg2_packet[11:9],
                         bg3_packet[17:13], bg3_packet[11:9],
                         dispcnt[15:13], dispcnt[6:0], bldcnt[15:14],
                         bldalpha[15:13], bldalpha[7:5], bldy[15:5],
                         pal_data[15], 1'(PAL_LAT)};

endmodule
